// File: rtl/counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_ctrl
// Purpose  : Command sequencer driving a loadable up-counter (load/step/run-to)
// Revision : 1.0
// ============================================================================
module counter_ctrl #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             abort,
    input  logic [WIDTH-1:0] count,
    output logic             load,
    output logic [WIDTH-1:0] data,
    output logic             enable,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0]       c_OP_NOP  = 2'b00;
    localparam logic [1:0]       c_OP_LOAD = 2'b01;
    localparam logic [1:0]       c_OP_STEP = 2'b10;
    localparam logic [1:0]       c_OP_RUN  = 2'b11;
    localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_ZERO    = '0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_STEP = 3'd2,
        S_RUN  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_arg;
    logic [WIDTH-1:0] r_remain;
    logic [WIDTH-1:0] r_data;

    logic w_accept;
    logic w_at_target;
    logic w_step_last;

    assign cmd_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_at_target = (count == r_arg);
    assign w_step_last = (r_remain == c_ONE);

    // The load value is presented straight from the latched argument during
    // LOAD so an aborted load never disturbs the held data value.
    assign data = (r_state == S_LOAD) ? r_arg : r_data;

    // Strobes are decoded from state so abort and count can gate them in the
    // same cycle they occur.
    always_comb begin
        load   = 1'b0;
        enable = 1'b0;
        done   = 1'b0;
        if (!abort) begin
            case (r_state)
                S_LOAD: begin
                    load = 1'b1;
                    done = 1'b1;
                end
                S_STEP: begin
                    enable = 1'b1;
                    done   = w_step_last;
                end
                S_RUN: begin
                    enable = !w_at_target;
                    done   = w_at_target;
                end
                S_FIN: begin
                    done = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state  <= S_IDLE;
            r_arg    <= c_ZERO;
            r_remain <= c_ZERO;
            r_data   <= c_ZERO;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_arg <= cmd_arg;
                        case (cmd_op)
                            c_OP_NOP:  r_state <= S_FIN;
                            c_OP_LOAD: r_state <= S_LOAD;
                            c_OP_STEP: begin
                                if (cmd_arg == c_ZERO) begin
                                    r_state <= S_FIN;
                                end else begin
                                    r_remain <= cmd_arg;
                                    r_state  <= S_STEP;
                                end
                            end
                            c_OP_RUN:  r_state <= S_RUN;
                            default:   r_state <= S_IDLE;
                        endcase
                    end
                end
                S_LOAD: begin
                    if (!abort) begin
                        r_data <= r_arg;
                    end
                    r_state <= S_IDLE;
                end
                S_STEP: begin
                    if (abort || w_step_last) begin
                        r_remain <= c_ZERO;
                        r_state  <= S_IDLE;
                    end else begin
                        r_remain <= r_remain - c_ONE;
                    end
                end
                S_RUN: begin
                    if (abort || w_at_target) begin
                        r_state <= S_IDLE;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_counter_ctrl.sv
`default_nettype none
// Testbench for counter_ctrl: a behavioural 5-bit counter closes the loop and
// each command's strobe trace is compared with a per-command expectation model.
module tb_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst_;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [4:0] cmd_arg;
    logic       abort;
    logic [4:0] count;
    logic       load;
    logic [4:0] data;
    logic       enable;
    logic       busy;
    logic       done;

    int         n_chk  = 0;
    int         n_pass = 0;
    logic [4:0] m_cnt  = 5'd0;

    counter_ctrl #(.WIDTH(5)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .abort     (abort),
        .count     (count),
        .load      (load),
        .data      (data),
        .enable    (enable),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // The counter being controlled
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)       count <= 5'd0;
        else if (load)   count <= data;
        else if (enable) count <= count + 5'd1;
    end

    // Expected shape of one command: cycles busy, enables, loads, done cycle.
    task automatic model_cmd(input logic [1:0] op, input logic [4:0] arg,
                             output int elen, output int een, output int eld,
                             output int edidx);
        int k;
        elen = 1; een = 0; eld = 0; edidx = 1;
        case (op)
            2'd1: begin eld = 1; m_cnt = arg; end
            2'd2: if (arg != 0) begin
                elen = arg; een = arg; edidx = arg;
                m_cnt = 5'((int'(m_cnt) + int'(arg)) % 32);
            end
            2'd3: begin
                k = (32 + int'(arg) - int'(m_cnt)) % 32;
                elen = k + 1; een = k; edidx = k + 1;
                m_cnt = arg;
            end
            default: ;
        endcase
    endtask

    // Issue one command at a negedge with the DUT idle; observe until idle.
    task automatic run_cmd(input logic [1:0] op, input logic [4:0] arg,
                           output int len, output int en, output int ld,
                           output int dn, output int didx, output int ovl,
                           output logic [4:0] ldat);
        len = 0; en = 0; ld = 0; dn = 0; didx = 0; ovl = 0; ldat = 5'd0;
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (!cmd_ready && len < 80) begin
            len++;
            if (load)   begin ld++; ldat = data; end
            if (enable) en++;
            if (done)   begin dn++; didx = len; end
            if (load && enable) ovl++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_ = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = 5'd0; abort = 1'b0;
        #12;
        n_chk++;
        if ({load, enable, done, busy, cmd_ready, data} !== {4'b0000, 1'b1, 5'd0})
            $display("FAIL reset_outputs: got %b want %b",
                     {load, enable, done, busy, cmd_ready, data}, {4'b0000, 1'b1, 5'd0});
        else n_pass++;
        @(negedge clk); rst_ = 1'b1; m_cnt = 5'd0;
        @(negedge clk);
    endtask

    task automatic test_load_run();
        int len, en, ld, dn, didx, ovl, elen, een, eld, edidx;
        logic [4:0] ldat;
        model_cmd(2'd1, 5'd17, elen, een, eld, edidx);
        run_cmd(2'd1, 5'd17, len, en, ld, dn, didx, ovl, ldat);
        n_chk++; if (ld !== eld || ldat !== 5'd17) $display("FAIL load17_strobe: got ld=%0d data=%0d want ld=%0d data=17", ld, ldat, eld); else n_pass++;
        n_chk++; if (len !== elen || didx !== edidx || dn !== 1) $display("FAIL load17_timing: got len=%0d done@%0d x%0d want len=%0d done@%0d x1", len, didx, dn, elen, edidx); else n_pass++;
        model_cmd(2'd3, 5'd20, elen, een, eld, edidx);
        run_cmd(2'd3, 5'd20, len, en, ld, dn, didx, ovl, ldat);
        n_chk++; if (en !== een) $display("FAIL run20_enables: got %0d want %0d", en, een); else n_pass++;
        n_chk++; if (didx !== edidx || dn !== 1) $display("FAIL run20_done: got done@%0d x%0d want done@%0d x1", didx, dn, edidx); else n_pass++;
        n_chk++; if (count !== m_cnt) $display("FAIL run20_count: got %0d want %0d", count, m_cnt); else n_pass++;
    endtask

    task automatic test_run_wrap();
        int len, en, ld, dn, didx, ovl, elen, een, eld, edidx;
        logic [4:0] ldat;
        model_cmd(2'd1, 5'd30, elen, een, eld, edidx);
        run_cmd(2'd1, 5'd30, len, en, ld, dn, didx, ovl, ldat);
        model_cmd(2'd3, 5'd2, elen, een, eld, edidx);
        run_cmd(2'd3, 5'd2, len, en, ld, dn, didx, ovl, ldat);
        n_chk++; if (en !== een || een !== 4) $display("FAIL wrap_enables: got %0d want 4", en); else n_pass++;
        n_chk++; if (dn !== 1 || count !== 5'd2) $display("FAIL wrap_end: got done x%0d count=%0d want x1 count=2", dn, count); else n_pass++;
    endtask

    task automatic test_step();
        int len, en, ld, dn, didx, ovl, elen, een, eld, edidx;
        logic [4:0] ldat;
        model_cmd(2'd2, 5'd0, elen, een, eld, edidx);
        run_cmd(2'd2, 5'd0, len, en, ld, dn, didx, ovl, ldat);
        n_chk++; if (en !== 0 || didx !== 1 || len !== elen) $display("FAIL step0: got en=%0d done@%0d len=%0d want en=0 done@1 len=%0d", en, didx, len, elen); else n_pass++;
        model_cmd(2'd1, 5'd0, elen, een, eld, edidx);
        run_cmd(2'd1, 5'd0, len, en, ld, dn, didx, ovl, ldat);
        model_cmd(2'd2, 5'd31, elen, een, eld, edidx);
        run_cmd(2'd2, 5'd31, len, en, ld, dn, didx, ovl, ldat);
        n_chk++; if (en !== 31 || didx !== 31 || dn !== 1) $display("FAIL step31: got en=%0d done@%0d x%0d want en=31 done@31 x1", en, didx, dn); else n_pass++;
        n_chk++; if (count !== 5'd31) $display("FAIL step31_count: got %0d want 31", count); else n_pass++;
    endtask

    task automatic test_abort();
        int len, en, ld, dn, didx, ovl, elen, een, eld, edidx, e, d;
        logic [4:0] ldat;
        model_cmd(2'd1, 5'd7, elen, een, eld, edidx);
        run_cmd(2'd1, 5'd7, len, en, ld, dn, didx, ovl, ldat);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_arg = 5'd10;
        @(negedge clk);
        cmd_valid = 1'b0; e = 0; d = 0;
        repeat (3) begin
            if (enable) e++;
            if (done) d++;
            @(negedge clk);
        end
        abort = 1'b1; #1;
        n_chk++; if ({load, enable, done} !== 3'b000) $display("FAIL abort_gate: got %b want 000", {load, enable, done}); else n_pass++;
        @(negedge clk); abort = 1'b0;
        n_chk++; if (cmd_ready !== 1'b1 || done !== 1'b0) $display("FAIL abort_ready: got ready=%b done=%b want 1 0", cmd_ready, done); else n_pass++;
        n_chk++; if (e !== 3 || d !== 0 || count !== 5'd10) $display("FAIL abort_count: got en=%0d done=%0d count=%0d want 3 0 10", e, d, count); else n_pass++;
        m_cnt = 5'd10;
        // abort while idle must not block a new command
        abort = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd1; cmd_arg = 5'd3;
        @(negedge clk);
        abort = 1'b0; cmd_valid = 1'b0; #1;
        n_chk++; if (load !== 1'b1 || data !== 5'd3) $display("FAIL idle_abort_accept: got load=%b data=%0d want 1 3", load, data); else n_pass++;
        @(negedge clk); m_cnt = 5'd3;
    endtask

    task automatic test_run_equal();
        int len, en, ld, dn, didx, ovl, elen, een, eld, edidx;
        logic [4:0] ldat;
        model_cmd(2'd1, 5'd9, elen, een, eld, edidx);
        run_cmd(2'd1, 5'd9, len, en, ld, dn, didx, ovl, ldat);
        model_cmd(2'd3, 5'd9, elen, een, eld, edidx);
        run_cmd(2'd3, 5'd9, len, en, ld, dn, didx, ovl, ldat);
        n_chk++; if (en !== 0 || didx !== 1 || dn !== 1 || len !== elen) $display("FAIL run_equal: got en=%0d done@%0d x%0d len=%0d want 0 1 1 %0d", en, didx, dn, len, elen); else n_pass++;
    endtask

    task automatic test_back_to_back_nop();
        int acc, dn, bad;
        logic [5:0] mask;
        acc = 0; dn = 0; bad = 0; mask = 6'd0;
        cmd_op = 2'd0; cmd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (cmd_valid && cmd_ready) begin acc++; mask[i] = 1'b1; end
            if (done) dn++;
            if (load || enable) bad++;
            if (i == 5) cmd_valid = 1'b0;
            @(negedge clk);
        end
        n_chk++; if (acc !== 3 || mask !== 6'b010101) $display("FAIL nop_accept: got %0d mask=%b want 3 mask=010101", acc, mask); else n_pass++;
        n_chk++; if (dn !== 3 || bad !== 0) $display("FAIL nop_done: got done=%0d strobes=%0d want 3 0", dn, bad); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int len, en, ld, dn, didx, ovl, elen, een, eld, edidx;
        logic [4:0] ldat;
        model_cmd(2'd1, 5'd0, elen, een, eld, edidx);
        run_cmd(2'd1, 5'd0, len, en, ld, dn, didx, ovl, ldat);
        cmd_valid = 1'b1; cmd_op = 2'd3; cmd_arg = 5'd20;
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        n_chk++; if (enable !== 1'b1) $display("FAIL midrun_enable: got %b want 1", enable); else n_pass++;
        #1 rst_ = 1'b0; #1;
        n_chk++; if ({enable, load, busy, done, data} !== 9'd0) $display("FAIL midrun_reset: got %b want 0", {enable, load, busy, done, data}); else n_pass++;
        @(negedge clk); rst_ = 1'b1; m_cnt = 5'd0;
        n_chk++; if (cmd_ready !== 1'b1) $display("FAIL midrun_ready: got %b want 1", cmd_ready); else n_pass++;
    endtask

    task automatic test_random();
        int len, en, ld, dn, didx, ovl, elen, een, eld, edidx;
        logic [4:0] ldat, arg;
        logic [1:0] op;
        for (int i = 0; i < 30; i++) begin
            op  = 2'($urandom % 4);
            arg = (op == 2'd2) ? 5'($urandom_range(0, 12)) : 5'($urandom % 32);
            model_cmd(op, arg, elen, een, eld, edidx);
            run_cmd(op, arg, len, en, ld, dn, didx, ovl, ldat);
            n_chk++; if (len !== elen) $display("FAIL rnd%0d_len op=%0d arg=%0d: got %0d want %0d", i, op, arg, len, elen); else n_pass++;
            n_chk++; if (en !== een) $display("FAIL rnd%0d_enables op=%0d arg=%0d: got %0d want %0d", i, op, arg, en, een); else n_pass++;
            n_chk++; if (ld !== eld) $display("FAIL rnd%0d_loads op=%0d: got %0d want %0d", i, op, ld, eld); else n_pass++;
            n_chk++; if (dn !== 1 || didx !== edidx) $display("FAIL rnd%0d_done op=%0d: got x%0d @%0d want x1 @%0d", i, op, dn, didx, edidx); else n_pass++;
            n_chk++; if (ovl !== 0) $display("FAIL rnd%0d_overlap: got %0d want 0", i, ovl); else n_pass++;
            n_chk++; if (count !== m_cnt) $display("FAIL rnd%0d_count op=%0d arg=%0d: got %0d want %0d", i, op, arg, count, m_cnt); else n_pass++;
            if (op == 2'd1) begin
                n_chk++; if (ldat !== arg || data !== arg) $display("FAIL rnd%0d_data: got %0d/%0d want %0d", i, ldat, data, arg); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_run();
        test_run_wrap();
        test_step();
        test_abort();
        test_run_equal();
        test_back_to_back_nop();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
Command sequencer directly upstream of the 5-bit loadable up-counter. Accepts operations over a valid/ready command interface and drives the counter's load, data and enable inputs. Reads the counter's count output back so it can run the counter to a target value. Reports completion with a one-cycle done pulse.

Parameters:
WIDTH, 5, width of data, count and cmd_arg; must match the counter width.

Ports:
clk        input   1      clock
rst_       input   1      reset, asynchronous, active-low
cmd_valid  input   1      command present
cmd_ready  output  1      controller can accept a command
cmd_op     input   2      00 NOP, 01 LOAD, 10 STEP, 11 RUN_TO
cmd_arg    input   WIDTH  LOAD value / STEP cycle count / RUN_TO target
abort      input   1      synchronous cancel of the operation in progress
count      input   WIDTH  current value fed back from the counter
load       output  1      counter load strobe
data       output  WIDTH  counter load value
enable     output  1      counter increment enable
busy       output  1      high whenever state != IDLE
done       output  1      one-cycle pulse when a command completes normally

Behaviour:
- Reset (rst_ low, asynchronous):
  - State = IDLE.
  - load=0, enable=0, data=0, done=0, busy=0, internal step counter=0, latched arg=0.
- cmd_ready = (state==IDLE); combinational, no dependence on cmd_valid.
- Accept: cmd_valid && cmd_ready at a clk edge. cmd_op and cmd_arg are captured into registers at that edge. Call the acceptance cycle T.
- FSM states: IDLE, LOAD, STEP, RUN, FIN.
- NOP: IDLE -> FIN. At T+1, done=1 and load/enable stay 0. FIN -> IDLE.
- LOAD:
  - IDLE -> LOAD.
  - At T+1, load=1 and data=arg. done=1 in the same cycle.
  - LOAD -> IDLE. cmd_ready is high again at T+2.
  - data holds the last loaded value until the next LOAD or reset.
- STEP n:
  - n=0 behaves exactly as NOP.
  - Otherwise IDLE -> STEP and the remaining counter = n.
  - enable=1 for exactly n consecutive cycles, T+1 .. T+n.
  - done=1 in cycle T+n, i.e. the last enable cycle. Then -> IDLE.
- RUN_TO target:
  - IDLE -> RUN.
  - In RUN, enable = (count != target). This is combinational from the count input.
  - done=1 in the first RUN cycle where count == target; that same cycle -> IDLE.
  - If count already equals target at T+1: zero enables, done at T+1.
  - Otherwise the number of enable cycles = (target - count) mod 2^WIDTH, using wrap-around arithmetic. The counter wraps, so RUN always terminates within 2^WIDTH cycles.
- load and enable are never both 1 in the same cycle.
- done is only ever 1 for a single cycle per command.
- abort:
  - In any non-IDLE state: load and enable are forced 0 in that same cycle, done is not asserted, and the next state is IDLE.
  - Ignored in IDLE. A command presented in the same cycle as abort while IDLE is still accepted.
- Unknown states recover to IDLE.
- Widths: all arg/count comparisons and arithmetic are WIDTH bits, unsigned, modulo 2^WIDTH.

Test Plan:
- Reset mid-RUN (rst_ low while enable=1) -> enable=0, load=0, data=0, busy=0 immediately (asynchronous). After release, cmd_ready=1.
- LOAD 5'd17, then RUN_TO 5'd20 back-to-back:
  - load=1/data=17 for one cycle, done pulse; next command accepted two cycles after the first.
  - enable high exactly 3 cycles, count ends at 20, done in the cycle count==20.
- RUN_TO wrap: LOAD 30, then RUN_TO 2 -> enable high 4 cycles (30->31->0->1->2), done once, count=2.
- STEP 0 and STEP 31:
  - STEP 0 -> no enable, done at T+1.
  - STEP 31 from count=0 -> enable high exactly 31 cycles, count=31, done on the 31st.
- Abort: STEP 10 aborted on the 4th enable cycle -> enable low in that cycle, count advances by 3 only, no done, cmd_ready=1 next cycle.
- RUN_TO equal target (count=9, target 9) -> no enable, done at T+1.
- NOP with cmd_valid held for 3 commands -> one acceptance every 2 cycles, 3 done pulses, load/enable never asserted.
